// File: rtl/dsp_pkg.sv
// Shared constants for the MAC pipeline.
// The opmode word carries, per operand set:
//   [OP_PRESUB]             1: pre = d - b, 0: pre = d + b
//   [OP_POSTSUB]            1: r = m - z,   0: r = m + z
//   [OP_ZMUX_HI:OP_ZMUX_LO] post-adder z source (ZC / ZP / Z0, 2'b11 behaves as Z0)
// DSP_LAT is the in_valid -> out_valid latency in clock cycles.
package dsp_pkg;

  localparam logic [1:0] ZC = 2'b00;   // z = c, aligned with m
  localparam logic [1:0] ZP = 2'b01;   // z = current p (accumulate)
  localparam logic [1:0] Z0 = 2'b10;   // z = 0

  localparam int OP_PRESUB  = 0;
  localparam int OP_POSTSUB = 1;
  localparam int OP_ZMUX_LO = 2;
  localparam int OP_ZMUX_HI = 3;

  localparam int DSP_LAT = 4;

endpackage

// File: rtl/dsp_postadd_sat.sv
// Post-adder with range check and optional saturation.
// Ports:
//   m      in  M_W  signed product
//   z      in  P_W  signed post-adder operand
//   sub    in  1    1: r = m - z, 0: r = m + z
//   p_next out P_W  result, clamped (SAT=1) or wrapped (SAT=0)
//   ovf    out 1    r does not fit in P_W signed bits
// Purely combinational; the caller owns the output register.
module dsp_postadd_sat #(
  parameter int P_W = 48,
  parameter int M_W = 37,
  parameter int SAT = 0
) (
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] z,
  input  logic           sub,
  output logic [P_W-1:0] p_next,
  output logic           ovf
);

  logic signed [P_W:0] m_ext;
  logic signed [P_W:0] z_ext;
  logic signed [P_W:0] r;

  // One guard bit is enough: |m| and |z| both fit in P_W bits, so m +/- z
  // always fits in P_W+1. Overflow shows up as the top two bits differing.
  function automatic logic [P_W-1:0] sat_wrap(input logic signed [P_W:0] v);
    logic over;
    over = v[P_W] ^ v[P_W-1];
    if ((SAT != 0) && over)
      sat_wrap = v[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
    else
      sat_wrap = v[P_W-1:0];
  endfunction

  always_comb begin
    m_ext  = (P_W+1)'($signed(m));
    z_ext  = (P_W+1)'($signed(z));
    r      = sub ? (m_ext - z_ext) : (m_ext + z_ext);
    ovf    = r[P_W] ^ r[P_W-1];
    p_next = sat_wrap(r);
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Four-stage pipelined pre-add / multiply / post-add MAC.
//   p = a * (d +/- b) +/- z,  z in {c, p, 0}
// Ports:
//   clk       in  1    rising-edge clock
//   rst       in  1    asynchronous active-high reset
//   in_valid  in  1    operand set present this cycle
//   a         in  A_W  signed multiplicand
//   b, d      in  B_W/D_W signed pre-adder operands
//   c         in  C_W  signed post-adder operand
//   opmode    in  4    [0] pre-sub, [1] post-sub, [3:2] zmux
//   out_valid out 1    one-cycle pulse per completed valid set
//   p         out P_W  signed result, held between valid results
//   ovf       out 1    overflow flag of the result currently on p
// Every register is cleared by rst so in-flight sets are discarded and an
// accumulate after reset starts from p = 0.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int D_W = 18,
  parameter int C_W = 48,
  parameter int P_W = 48,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [D_W-1:0] d,
  input  logic [C_W-1:0] c,
  input  logic [3:0]     opmode,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int PA_W = ((B_W > D_W) ? B_W : D_W) + 1;
  localparam int M_W  = A_W + PA_W;

  if ((P_W < M_W) || (P_W < C_W)) begin : g_width_check
    $error("dsp_mac_pipe: P_W must be at least A_W+max(B_W,D_W)+1 and at least C_W");
  end

  // S1: operand capture
  logic signed [A_W-1:0] a_p0;
  logic signed [B_W-1:0] b_p0;
  logic signed [D_W-1:0] d_p0;
  logic signed [C_W-1:0] c_p0;
  logic [3:0]            op_p0;
  logic                  vld_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0   <= '0;
      b_p0   <= '0;
      d_p0   <= '0;
      c_p0   <= '0;
      op_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      a_p0   <= a;
      b_p0   <= b;
      d_p0   <= d;
      c_p0   <= c;
      op_p0  <= opmode;
      vld_p0 <= in_valid;
    end
  end

  // S2: pre-adder
  logic signed [PA_W-1:0] pre_c;
  logic signed [A_W-1:0]  a_p1;
  logic signed [PA_W-1:0] pre_p1;
  logic signed [C_W-1:0]  c_p1;
  logic                   sub_p1;
  logic [1:0]             zmux_p1;
  logic                   vld_p1;

  always_comb begin
    if (op_p0[OP_PRESUB])
      pre_c = PA_W'(d_p0) - PA_W'(b_p0);
    else
      pre_c = PA_W'(d_p0) + PA_W'(b_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p1    <= '0;
      pre_p1  <= '0;
      c_p1    <= '0;
      sub_p1  <= 1'b0;
      zmux_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      a_p1    <= a_p0;
      pre_p1  <= pre_c;
      c_p1    <= c_p0;
      sub_p1  <= op_p0[OP_POSTSUB];
      zmux_p1 <= op_p0[OP_ZMUX_HI:OP_ZMUX_LO];
      vld_p1  <= vld_p0;
    end
  end

  // S3: multiplier
  logic signed [M_W-1:0] m_c;
  logic signed [M_W-1:0] m_p2;
  logic signed [C_W-1:0] c_p2;
  logic                  sub_p2;
  logic [1:0]            zmux_p2;
  logic                  vld_p2;

  // Both factors widened to M_W so the product is formed at full precision.
  assign m_c = M_W'(a_p1) * M_W'(pre_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p2    <= '0;
      c_p2    <= '0;
      sub_p2  <= 1'b0;
      zmux_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      m_p2    <= m_c;
      c_p2    <= c_p1;
      sub_p2  <= sub_p1;
      zmux_p2 <= zmux_p1;
      vld_p2  <= vld_p1;
    end
  end

  // S4: z select, post-add, range handling, output register
  logic signed [P_W-1:0] p_q;
  logic signed [P_W-1:0] z_c;
  logic [P_W-1:0]        p_next;
  logic                  ovf_next;

  // ZP reads p_q directly: the previous valid result is already registered
  // when the next entry reaches this stage, so back-to-back accumulates
  // need no forwarding path or stall.
  always_comb begin
    case (zmux_p2)
      ZC:      z_c = P_W'(c_p2);
      ZP:      z_c = p_q;
      default: z_c = '0;
    endcase
  end

  dsp_postadd_sat #(
    .P_W (P_W),
    .M_W (M_W),
    .SAT (SAT)
  ) u_postadd (
    .m      (m_p2),
    .z      (z_c),
    .sub    (sub_p2),
    .p_next (p_next),
    .ovf    (ovf_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        p_q <= p_next;
        ovf <= ovf_next;
      end
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a wrapping (SAT=0) and a saturating (SAT=1)
// instance share one stimulus stream. A behavioural model computes each
// result with plain integer arithmetic when the set is applied and delays
// it by DSP_LAT cycles; a negedge process compares both instances to it
// every cycle. Directed scenarios also pin literal results.
module tb_dsp_mac_pipe;
  import dsp_pkg::*;

  localparam int     P_W   = 48;
  localparam longint P_MAX = (64'sd1 <<< (P_W-1)) - 64'sd1;
  localparam longint P_MIN = -(64'sd1 <<< (P_W-1));
  localparam longint P_MOD = 64'sd1 <<< P_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic [3:0]  opmode;

  logic        ov_w, ov_s, ovf_w, ovf_s;
  logic [47:0] p_w, p_s;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .opmode(opmode), .out_valid(ov_w), .p(p_w), .ovf(ovf_w)
  );

  dsp_mac_pipe #(.SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .opmode(opmode), .out_valid(ov_s), .p(p_s), .ovf(ovf_s)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit     vld;
    longint pw;
    longint ps;
    bit     ow;
    bit     os;
  } ent_t;

  ent_t   dly [DSP_LAT];
  ent_t   hold;
  ent_t   e;
  longint acc_w, acc_s;
  longint m_av, m_bv, m_dv, m_cv, m_pre, m_m, m_z, m_r;

  function automatic bit out_of_range(input longint r);
    return (r > P_MAX) || (r < P_MIN);
  endfunction

  function automatic longint settle(input longint r, input bit sat);
    if (r > P_MAX) return sat ? P_MAX : r - P_MOD;
    if (r < P_MIN) return sat ? P_MIN : r + P_MOD;
    return r;
  endfunction

  function automatic longint pick_z(input logic [1:0] zm, input longint cv, input longint acc);
    if (zm == ZC) return cv;
    if (zm == ZP) return acc;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DSP_LAT; i++) dly[i] = '{vld: 1'b0, pw: 0, ps: 0, ow: 1'b0, os: 1'b0};
      hold  = '{vld: 1'b0, pw: 0, ps: 0, ow: 1'b0, os: 1'b0};
      acc_w = 0;
      acc_s = 0;
    end else begin
      e = '{vld: in_valid, pw: 0, ps: 0, ow: 1'b0, os: 1'b0};
      if (in_valid) begin
        m_av  = longint'($signed(a));
        m_bv  = longint'($signed(b));
        m_dv  = longint'($signed(d));
        m_cv  = longint'($signed(c));
        m_pre = opmode[0] ? (m_dv - m_bv) : (m_dv + m_bv);
        m_m   = m_av * m_pre;
        m_z   = pick_z(opmode[3:2], m_cv, acc_w);
        m_r   = opmode[1] ? (m_m - m_z) : (m_m + m_z);
        e.pw  = settle(m_r, 1'b0);
        e.ow  = out_of_range(m_r);
        m_z   = pick_z(opmode[3:2], m_cv, acc_s);
        m_r   = opmode[1] ? (m_m - m_z) : (m_m + m_z);
        e.ps  = settle(m_r, 1'b1);
        e.os  = out_of_range(m_r);
        acc_w = e.pw;
        acc_s = e.ps;
      end
      for (int i = DSP_LAT-1; i > 0; i--) dly[i] = dly[i-1];
      dly[0] = e;
      if (dly[DSP_LAT-1].vld) hold = dly[DSP_LAT-1];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_vld_w", longint'(ov_w), 0);
      chk("rst_vld_s", longint'(ov_s), 0);
      chk("rst_p_w", longint'($signed(p_w)), 0);
      chk("rst_p_s", longint'($signed(p_s)), 0);
      chk("rst_ovf_w", longint'(ovf_w), 0);
      chk("rst_ovf_s", longint'(ovf_s), 0);
    end else begin
      chk("vld_w", longint'(ov_w), longint'(dly[DSP_LAT-1].vld));
      chk("vld_s", longint'(ov_s), longint'(dly[DSP_LAT-1].vld));
      chk("p_w", longint'($signed(p_w)), hold.pw);
      chk("p_s", longint'($signed(p_s)), hold.ps);
      chk("ovf_w", longint'(ovf_w), longint'(hold.ow));
      chk("ovf_s", longint'(ovf_s), longint'(hold.os));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input bit v, input longint av, input longint bv, input longint dv,
                       input longint cv, input logic [3:0] op);
    @(negedge clk);
    in_valid = v;
    a        = 18'(av);
    b        = 18'(bv);
    d        = 18'(dv);
    c        = 48'(cv);
    opmode   = op;
  endtask

  // Bubble with non-trivial operands and an accumulate opcode: must not touch p.
  task automatic idle();
    drive(1'b0, 7, 3, 9, 123, {ZP, 2'b00});
  endtask

  task automatic lit(input string nm, input longint ev, input longint epw, input longint eow,
                     input longint eps, input longint eos);
    chk({nm, "_vld_w"}, longint'(ov_w), ev);
    chk({nm, "_vld_s"}, longint'(ov_s), ev);
    chk({nm, "_p_w"}, longint'($signed(p_w)), epw);
    chk({nm, "_ovf_w"}, longint'(ovf_w), eow);
    chk({nm, "_p_s"}, longint'($signed(p_s)), eps);
    chk({nm, "_ovf_s"}, longint'(ovf_s), eos);
  endtask

  longint pat_v [5] = '{1, 0, 1, 1, 0};
  longint pat_p [5] = '{6, 6, 2, 7, 7};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    d        = '0;
    c        = '0;
    opmode   = '0;
    repeat (3) @(negedge clk);
    lit("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // 3*(5+2)+10 = 31
    drive(1'b1, 3, 2, 5, 10, {ZC, 2'b00});
    repeat (4) idle();
    lit("basic", 1, 31, 0, 31, 0);

    // Load 4 then accumulate 4 three times
    drive(1'b1, 1, 0, 4, 999, {Z0, 2'b00});
    repeat (3) drive(1'b1, 1, 0, 4, 999, {ZP, 2'b00});
    for (int i = 0; i < 4; i++) begin
      idle();
      lit("acc", 1, 4 * (i + 1), 0, 4 * (i + 1), 0);
    end

    // Positive overflow: 1 + (2^47-1)
    drive(1'b1, 1, 0, 1, P_MAX, {ZC, 2'b00});
    // Negative overflow: -1 + (-2^47)
    drive(1'b1, -1, 0, 1, P_MIN, {ZC, 2'b00});
    repeat (3) idle();
    lit("ovf_pos", 1, P_MIN, 1, P_MAX, 1);
    idle();
    lit("ovf_neg", 1, P_MAX, 1, P_MIN, 1);

    // 3*(5-2)-10 = -1, then -4*(2+1)+0 = -12; ovf must clear
    drive(1'b1, 3, 2, 5, 10, {ZC, 2'b11});
    drive(1'b1, -4, 1, 2, 0, {ZC, 2'b00});
    repeat (3) idle();
    lit("postsub", 1, -1, 0, -1, 0);
    idle();
    lit("neg", 1, -12, 0, -12, 0);

    // Bubbles: valid pattern 1,0,1,1,0 with p holding across gaps
    drive(1'b1, 2, 0, 3, 0, {Z0, 2'b00});
    idle();
    drive(1'b1, 1, 1, 1, 0, {Z0, 2'b00});
    drive(1'b1, 5, 0, 1, 0, {ZP, 2'b00});
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) idle();
      lit("bubble", pat_v[i], pat_p[i], 0, pat_p[i], 0);
    end

    // Reset with three sets in flight
    drive(1'b1, 5, 0, 5, 0, {Z0, 2'b00});
    drive(1'b1, 6, 0, 5, 0, {Z0, 2'b00});
    drive(1'b1, 7, 0, 5, 0, {Z0, 2'b00});
    @(negedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    #1 lit("rst_async", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      lit("flushed", 0, 0, 0, 0, 0);
    end
    drive(1'b1, 1, 0, 7, 0, {ZP, 2'b00});
    repeat (4) idle();
    lit("post_rst_acc", 1, 7, 0, 7, 0);
    repeat (2) idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
